rsa_xcel_mont_modexp_arbiter: RTL and testbench

//  Shares one Montgomery modexp unit (96b {mod,exp,base} in, 32b result out) among NREQ requesters.

---
 rtl/rsa_xcel_mont_modexp_arbiter_if.sv | 38 +++
 rtl/rsa_xcel_mont_modexp_arbiter.sv | 114 +++++++++++
 tb/tb_rsa_xcel_mont_modexp_arbiter.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_xcel_mont_modexp_arbiter_if.sv
// Bus bundle between the requester adapters, the modexp arbiter and the
// single shared Montgomery modexp unit.
interface rsa_xcel_mont_modexp_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int NBITS = 32
);
  // requester side: slice i of req_msg is {mod, exp, base}, base in the LSBs
  logic [NREQ-1:0][3*NBITS-1:0] req_msg;
  logic [NREQ-1:0]              req_val;
  logic [NREQ-1:0]              req_rdy;
  logic [NBITS-1:0]             resp_msg;
  logic [NREQ-1:0]              resp_val;
  logic [NREQ-1:0]              resp_rdy;

  // modexp unit side
  logic [3*NBITS-1:0]           modexp_istream_msg;
  logic                         modexp_istream_val;
  logic                         modexp_istream_rdy;
  logic [NBITS-1:0]             modexp_ostream_msg;
  logic                         modexp_ostream_val;
  logic                         modexp_ostream_rdy;

  // arbiter view
  modport slave (
    input  req_msg, req_val, resp_rdy,
    input  modexp_istream_rdy, modexp_ostream_msg, modexp_ostream_val,
    output req_rdy, resp_msg, resp_val,
    output modexp_istream_msg, modexp_istream_val, modexp_ostream_rdy
  );

  // environment view: requesters plus the modexp unit
  modport master (
    output req_msg, req_val, resp_rdy,
    output modexp_istream_rdy, modexp_ostream_msg, modexp_ostream_val,
    input  req_rdy, resp_msg, resp_val,
    input  modexp_istream_msg, modexp_istream_val, modexp_ostream_rdy
  );
endinterface

// File: rtl/rsa_xcel_mont_modexp_arbiter.sv
// Round-robin arbiter sharing one modexp unit among NREQ requesters.
// One operation in flight; the result is routed back only to the requester
// that issued it. IDLE -> WAIT -> RESP -> IDLE.
module rsa_xcel_mont_modexp_arbiter #(
  parameter int NREQ  = 4,
  parameter int NBITS = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  rsa_xcel_mont_modexp_arbiter_if.slave bus,
  output logic [$clog2(NREQ)-1:0]     owner,
  output logic                        busy,
  output logic [15:0]                 op_count
);
  localparam int PW = $clog2(NREQ);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    owner_q;
  logic [NBITS-1:0] result;
  logic [15:0]      op_cnt;

  logic [PW-1:0]    sel;
  logic             any;
  int               cand;
  logic             issue;
  logic             deliver;
  logic             ifire;
  logic             ofire;
  logic             accept;
  logic [NREQ-1:0]  req_rdy_w;
  logic [NREQ-1:0]  resp_val_w;

  // Round-robin pick: lowest index at or after ptr with a valid request.
  // Scanning from the far end lets the nearest candidate overwrite last.
  always_comb begin
    sel  = ptr;
    any  = 1'b0;
    cand = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (bus.req_val[PW'(cand)]) begin
        sel = PW'(cand);
        any = 1'b1;
      end
    end
  end

  // Handshake qualifiers; every val/rdy output is forced low while reset is
  // held so nothing leaks out during an asynchronous reset.
  assign issue   = reset & (state == IDLE) & any;
  assign deliver = reset & (state == RESP);
  assign ifire   = issue & bus.modexp_istream_rdy;
  assign ofire   = reset & (state == WAIT) & bus.modexp_ostream_val;
  assign accept  = deliver & bus.resp_rdy[owner_q];

  assign bus.modexp_istream_val = issue;
  assign bus.modexp_istream_msg = issue ? bus.req_msg[sel] : '0;
  assign bus.modexp_ostream_rdy = reset & (state == WAIT);
  assign bus.resp_msg           = result;

  // Per-requester steering: ready only for the picked requester when the unit
  // takes the operands, response valid only for the recorded owner.
  for (genvar i = 0; i < NREQ; i++) begin : g_req
    assign req_rdy_w[i]  = ifire & (sel == PW'(i));
    assign resp_val_w[i] = deliver & (owner_q == PW'(i));
  end

  assign bus.req_rdy  = req_rdy_w;
  assign bus.resp_val = resp_val_w;

  // FSM and op bookkeeping; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ptr     <= '0;
      owner_q <= '0;
      result  <= '0;
      op_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ifire) begin
            owner_q <= sel;
            ptr     <= (sel == PW'(NREQ - 1)) ? '0 : sel + 1'b1;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (ofire) begin
            result <= bus.modexp_ostream_msg;
            state  <= RESP;
          end
        end
        RESP: begin
          if (accept) begin
            op_cnt <= op_cnt + 16'd1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign owner    = owner_q;
  assign busy     = (state != IDLE);
  assign op_count = op_cnt;
endmodule

// File: tb/tb_rsa_xcel_mont_modexp_arbiter.sv
// Bench for the modexp arbiter: behavioural modexp unit, event monitor, and a
// round-robin reference model computed from the pending request set.
module tb_rsa_xcel_mont_modexp_arbiter;
  localparam int NREQ  = 4;
  localparam int NBITS = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  owner;
  logic        busy;
  logic [15:0] op_count;

  int n_chk  = 0;
  int n_fail = 0;

  rsa_xcel_mont_modexp_arbiter_if #(.NREQ(NREQ), .NBITS(NBITS)) bus ();

  rsa_xcel_mont_modexp_arbiter #(.NREQ(NREQ), .NBITS(NBITS)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .owner    (owner),
    .busy     (busy),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  // reference arithmetic: base^exp mod mod by square-and-multiply
  function automatic logic [31:0] ref_modexp(input logic [95:0] m);
    logic [63:0] md, b, r;
    logic [31:0] e;
    md = {32'd0, m[95:64]};
    e  = m[63:32];
    if (md == 64'd0) return 32'd0;
    b = {32'd0, m[31:0]} % md;
    r = 64'd1 % md;
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = (r * b) % md;
      b = (b * b) % md;
    end
    return r[31:0];
  endfunction

  function automatic logic [95:0] rand_op();
    logic [31:0] m, e, b;
    m = $urandom_range(32'h7fffffff, 2);
    e = $urandom;
    b = $urandom;
    return {m, e, b};
  endfunction

  // behavioural modexp unit, shares the arbiter reset
  bit          mx_en;
  int          mx_delay;
  logic        mx_busy;
  int          mx_cnt;
  logic [31:0] mx_res;

  assign bus.modexp_istream_rdy = mx_en && !mx_busy;
  assign bus.modexp_ostream_val = mx_busy && (mx_cnt == 0);
  assign bus.modexp_ostream_msg = mx_res;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mx_busy <= 1'b0;
      mx_cnt  <= 0;
      mx_res  <= '0;
    end else if (bus.modexp_ostream_val && bus.modexp_ostream_rdy) begin
      mx_busy <= 1'b0;
    end else if (bus.modexp_istream_val && bus.modexp_istream_rdy) begin
      mx_busy <= 1'b1;
      mx_cnt  <= mx_delay;
      mx_res  <= ref_modexp(bus.modexp_istream_msg);
    end else if (mx_busy && mx_cnt > 0) begin
      mx_cnt <= mx_cnt - 1;
    end
  end

  // event monitor: grants with the operands seen by the unit, accepted responses
  int          grant_q[$];
  logic [95:0] imsg_q[$];
  int          rsp_own_q[$];
  logic [31:0] rsp_msg_q[$];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_val[i] && bus.req_rdy[i]) begin
          grant_q.push_back(i);
          imsg_q.push_back(bus.modexp_istream_msg);
        end
        if (bus.resp_val[i] && bus.resp_rdy[i]) begin
          rsp_own_q.push_back(i);
          rsp_msg_q.push_back(bus.resp_msg);
        end
      end
    end
  end

  // response valid is one-hot-or-zero and only while busy
  always @(negedge clk) begin
    if (reset) begin
      n_chk++;
      if (!$onehot0(bus.resp_val) || (bus.resp_val != '0 && !busy)) begin
        n_fail++;
        $display("FAIL resp_val_shape: resp_val=%b busy=%b, required at most one bit and only while busy",
                 bus.resp_val, busy);
      end
    end
  end

  // reference model state
  int          m_ptr;
  logic [15:0] m_ops;
  int          exp_q[$];
  logic [95:0] op_msg [NREQ];

  // serve a held request set: repeatedly take the first pending index at or after ptr
  function automatic void model_round(input logic [3:0] mask);
    logic [3:0] p;
    p = mask;
    while (p != 4'd0) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (p[i]) begin
          exp_q.push_back(i);
          p[i]  = 1'b0;
          m_ptr = (i + 1) % NREQ;
          break;
        end
      end
    end
  endfunction

  function automatic void clear_logs();
    grant_q.delete();
    imsg_q.delete();
    rsp_own_q.delete();
    rsp_msg_q.delete();
    exp_q.delete();
  endfunction

  // drive a request set, each requester drops val after its grant; waits for all responses
  task automatic run_round(input logic [3:0] mask, input bit all_rdy, output bit to);
    int g_seen, r_goal, cyc;
    g_seen = grant_q.size();
    r_goal = rsp_own_q.size() + $countones(mask);
    to  = 1'b0;
    cyc = 0;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) bus.req_msg[i] = op_msg[i];
    bus.req_val = mask;
    while (bus.req_val != '0 || rsp_own_q.size() < r_goal) begin
      bus.resp_rdy = all_rdy ? 4'hF : 4'($urandom);
      @(negedge clk);
      while (g_seen < grant_q.size()) begin
        bus.req_val[grant_q[g_seen]] = 1'b0;
        g_seen++;
      end
      cyc++;
      if (cyc > 2000) begin
        to = 1'b1;
        break;
      end
    end
    bus.req_val  = '0;
    bus.resp_rdy = '0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < NREQ; i++) bus.req_msg[i] = rand_op();
    bus.req_val  = 4'hF;
    bus.resp_rdy = 4'hF;
    @(negedge clk);
    @(negedge clk);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_chk++; if (op_count !== 16'd0) begin n_fail++; $display("FAIL rst_op_count: got %h want 0", op_count); end
    n_chk++; if (owner !== 2'd0) begin n_fail++; $display("FAIL rst_owner: got %0d want 0", owner); end
    n_chk++; if (bus.req_rdy !== 4'd0) begin n_fail++; $display("FAIL rst_req_rdy: got %b want 0000", bus.req_rdy); end
    n_chk++; if (bus.resp_val !== 4'd0) begin n_fail++; $display("FAIL rst_resp_val: got %b want 0000", bus.resp_val); end
    n_chk++; if (bus.modexp_istream_val !== 1'b0) begin n_fail++; $display("FAIL rst_istream_val: got %b want 0", bus.modexp_istream_val); end
    n_chk++; if (bus.modexp_ostream_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_ostream_rdy: got %b want 0", bus.modexp_ostream_rdy); end
    n_chk++; if (bus.modexp_istream_msg !== '0) begin n_fail++; $display("FAIL rst_istream_msg: got %h want 0", bus.modexp_istream_msg); end
    n_chk++; if (bus.resp_msg !== 32'd0) begin n_fail++; $display("FAIL rst_resp_msg: got %h want 0", bus.resp_msg); end
    bus.req_val  = '0;
    bus.resp_rdy = '0;
    @(negedge clk);
    reset = 1'b1;
    m_ptr = 0;
    m_ops = 16'd0;
  endtask

  task automatic test_single();
    bit to;
    clear_logs();
    op_msg[0] = {32'd497, 32'd13, 32'd4};
    mx_delay  = 3;
    model_round(4'b0001);
    run_round(4'b0001, 1'b1, to);
    m_ops = m_ops + 16'd1;
    n_chk++; if (to) begin n_fail++; $display("FAIL single_timeout: got timeout want completion"); end
    n_chk++;
    if (grant_q.size() != 1 || imsg_q.size() != 1) begin
      n_fail++; $display("FAIL single_fires: got %0d istream fires want 1", grant_q.size());
    end else if (grant_q[0] !== 0 || imsg_q[0] !== {32'd497, 32'd13, 32'd4}) begin
      n_fail++; $display("FAIL single_fire: got req %0d msg %h want req 0 msg {497,13,4}", grant_q[0], imsg_q[0]);
    end
    n_chk++;
    if (rsp_own_q.size() != 1) begin
      n_fail++; $display("FAIL single_resp_count: got %0d want 1", rsp_own_q.size());
    end else if (rsp_own_q[0] !== 0 || rsp_msg_q[0] !== 32'd445) begin
      n_fail++; $display("FAIL single_resp: got owner %0d msg %0d want owner 0 msg 445", rsp_own_q[0], rsp_msg_q[0]);
    end
    n_chk++; if (op_count !== m_ops) begin n_fail++; $display("FAIL single_op_count: got %0d want %0d", op_count, m_ops); end
  endtask

  // fixed mode: req3 alone (wraps ptr to 0) then all four held twice; random mode: random sets
  task automatic test_round_robin(input bit rnd);
    logic [3:0] mask;
    bit         to;
    int         rounds, n;
    rounds = rnd ? 16 : 3;
    for (int r = 0; r < rounds; r++) begin
      clear_logs();
      if (rnd) mask = 4'($urandom_range(15, 1));
      else     mask = (r == 0) ? 4'b1000 : 4'b1111;
      for (int i = 0; i < NREQ; i++) op_msg[i] = rand_op();
      mx_delay = $urandom_range(4, 0);
      model_round(mask);
      run_round(mask, 1'b0, to);
      n_chk++; if (to) begin n_fail++; $display("FAIL rr_timeout: round %0d got timeout want completion", r); end
      n_chk++;
      if (grant_q.size() != exp_q.size() || rsp_own_q.size() != exp_q.size()) begin
        n_fail++;
        $display("FAIL rr_count: round %0d got %0d grants %0d resps want %0d", r, grant_q.size(), rsp_own_q.size(), exp_q.size());
      end else begin
        for (int k = 0; k < exp_q.size(); k++) begin
          n_chk++;
          if (grant_q[k] !== exp_q[k] || imsg_q[k] !== op_msg[exp_q[k]]) begin
            n_fail++;
            $display("FAIL rr_grant: round %0d slot %0d got req %0d msg %h want req %0d msg %h",
                     r, k, grant_q[k], imsg_q[k], exp_q[k], op_msg[exp_q[k]]);
          end
          n_chk++;
          if (rsp_own_q[k] !== exp_q[k] || rsp_msg_q[k] !== ref_modexp(op_msg[exp_q[k]])) begin
            n_fail++;
            $display("FAIL rr_resp: round %0d slot %0d got owner %0d msg %h want owner %0d msg %h",
                     r, k, rsp_own_q[k], rsp_msg_q[k], exp_q[k], ref_modexp(op_msg[exp_q[k]]));
          end
        end
      end
      n = exp_q.size();
      m_ops = m_ops + 16'(n);
      n_chk++; if (op_count !== m_ops) begin n_fail++; $display("FAIL rr_op_count: got %0d want %0d", op_count, m_ops); end
    end
  endtask

  task automatic test_hold_resp();
    logic [31:0] expv;
    int          cyc;
    clear_logs();
    op_msg[2] = rand_op();
    expv      = ref_modexp(op_msg[2]);
    mx_delay  = 2;
    model_round(4'b0100);
    @(negedge clk);
    bus.req_msg[2] = op_msg[2];
    bus.resp_rdy   = '0;
    bus.req_val    = 4'b0100;
    cyc = 0;
    while (grant_q.size() == 0 && cyc < 50) begin @(negedge clk); cyc++; end
    n_chk++;
    if (grant_q.size() != 1) begin n_fail++; $display("FAIL hold_grant_count: got %0d want 1", grant_q.size()); end
    else if (grant_q[0] !== 2) begin n_fail++; $display("FAIL hold_grant: got %0d want 2", grant_q[0]); end
    // other requesters pile up while the op is out
    bus.req_val = 4'b1011;
    cyc = 0;
    while (!(bus.modexp_ostream_val && bus.modexp_ostream_rdy) && cyc < 50) begin @(negedge clk); cyc++; end
    @(negedge clk);
    n_chk++; if (bus.resp_val !== 4'b0100) begin n_fail++; $display("FAIL hold_latency: resp_val got %b want 0100 one cycle after ostream fire", bus.resp_val); end
    for (int c = 0; c < 10; c++) begin
      bus.resp_rdy = 4'($urandom) & 4'b1011;
      #1;
      n_chk++; if (bus.resp_val !== 4'b0100) begin n_fail++; $display("FAIL hold_resp_val: cyc %0d got %b want 0100", c, bus.resp_val); end
      n_chk++; if (bus.resp_msg !== expv) begin n_fail++; $display("FAIL hold_resp_msg: cyc %0d got %h want %h", c, bus.resp_msg, expv); end
      n_chk++; if (bus.req_rdy !== 4'd0 || bus.modexp_istream_val !== 1'b0) begin
        n_fail++; $display("FAIL hold_no_issue: cyc %0d got req_rdy %b istream_val %b want 0000 0", c, bus.req_rdy, bus.modexp_istream_val);
      end
      n_chk++; if (owner !== 2'd2 || busy !== 1'b1) begin n_fail++; $display("FAIL hold_owner: cyc %0d got owner %0d busy %b want 2 1", c, owner, busy); end
      @(negedge clk);
    end
    bus.req_val  = '0;
    bus.resp_rdy = 4'b0100;
    @(negedge clk);
    bus.resp_rdy = '0;
    m_ops = m_ops + 16'd1;
    n_chk++; if (busy !== 1'b0 || bus.resp_val !== 4'd0) begin n_fail++; $display("FAIL hold_release: got busy %b resp_val %b want 0 0000", busy, bus.resp_val); end
    n_chk++; if (rsp_own_q.size() != 1) begin n_fail++; $display("FAIL hold_accepts: got %0d want 1", rsp_own_q.size()); end
    n_chk++; if (op_count !== m_ops) begin n_fail++; $display("FAIL hold_op_count: got %0d want %0d", op_count, m_ops); end
  endtask

  task automatic test_istream_stall();
    bit to;
    int cyc;
    clear_logs();
    op_msg[1] = rand_op();
    mx_delay  = 1;
    mx_en     = 1'b0;
    model_round(4'b0010);
    @(negedge clk);
    bus.req_msg[1] = op_msg[1];
    bus.req_val    = 4'b0010;
    bus.resp_rdy   = 4'hF;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_chk++; if (bus.modexp_istream_val !== 1'b1 || bus.req_rdy !== 4'd0) begin
        n_fail++; $display("FAIL stall_hs: cyc %0d got istream_val %b req_rdy %b want 1 0000", c, bus.modexp_istream_val, bus.req_rdy);
      end
      n_chk++; if (busy !== 1'b0 || bus.modexp_istream_msg !== op_msg[1]) begin
        n_fail++; $display("FAIL stall_idle: cyc %0d got busy %b msg %h want 0 %h", c, busy, bus.modexp_istream_msg, op_msg[1]);
      end
      @(negedge clk);
    end
    mx_en = 1'b1;
    #1;
    n_chk++; if (bus.req_rdy !== 4'b0010) begin n_fail++; $display("FAIL stall_rdy: got %b want 0010", bus.req_rdy); end
    @(negedge clk);
    bus.req_val = '0;
    n_chk++; if (busy !== 1'b1 || owner !== 2'd1) begin n_fail++; $display("FAIL stall_fire: got busy %b owner %0d want 1 1", busy, owner); end
    cyc = 0;
    while (rsp_own_q.size() == 0 && cyc < 50) begin @(negedge clk); cyc++; end
    bus.resp_rdy = '0;
    m_ops = m_ops + 16'd1;
    n_chk++;
    if (rsp_own_q.size() != 1) begin n_fail++; $display("FAIL stall_resp_count: got %0d want 1", rsp_own_q.size()); end
    else if (rsp_msg_q[0] !== ref_modexp(op_msg[1])) begin n_fail++; $display("FAIL stall_resp: got %h want %h", rsp_msg_q[0], ref_modexp(op_msg[1])); end
    // ptr is now 2: with 1 and 2 both asking, 2 goes first
    clear_logs();
    op_msg[1] = rand_op();
    op_msg[2] = rand_op();
    model_round(4'b0110);
    run_round(4'b0110, 1'b1, to);
    m_ops = m_ops + 16'd2;
    n_chk++;
    if (to || grant_q.size() != 2) begin n_fail++; $display("FAIL stall_ptr_count: got %0d grants timeout %b want 2 0", grant_q.size(), to); end
    else if (grant_q[0] !== exp_q[0] || grant_q[1] !== exp_q[1]) begin
      n_fail++; $display("FAIL stall_ptr_order: got %0d,%0d want %0d,%0d", grant_q[0], grant_q[1], exp_q[0], exp_q[1]);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int cyc;
    clear_logs();
    op_msg[1] = rand_op();
    mx_delay  = 20;
    @(negedge clk);
    bus.req_msg[1] = op_msg[1];
    bus.req_val    = 4'b0010;
    bus.resp_rdy   = 4'hF;
    cyc = 0;
    while (grant_q.size() == 0 && cyc < 50) begin @(negedge clk); cyc++; end
    bus.req_val = '0;
    @(negedge clk);
    n_chk++; if (busy !== 1'b1 || bus.modexp_ostream_rdy !== 1'b1) begin n_fail++; $display("FAIL mid_wait: got busy %b ostream_rdy %b want 1 1", busy, bus.modexp_ostream_rdy); end
    bus.req_val = 4'b0110;
    #2 reset = 1'b0;
    #1;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
    n_chk++; if (bus.req_rdy !== 4'd0 || bus.modexp_istream_val !== 1'b0) begin
      n_fail++; $display("FAIL mid_req: got req_rdy %b istream_val %b want 0000 0", bus.req_rdy, bus.modexp_istream_val);
    end
    n_chk++; if (bus.resp_val !== 4'd0 || bus.modexp_ostream_rdy !== 1'b0) begin
      n_fail++; $display("FAIL mid_resp: got resp_val %b ostream_rdy %b want 0000 0", bus.resp_val, bus.modexp_ostream_rdy);
    end
    n_chk++; if (op_count !== 16'd0 || owner !== 2'd0) begin n_fail++; $display("FAIL mid_regs: got op_count %0d owner %0d want 0 0", op_count, owner); end
    @(negedge clk);
    bus.req_val  = '0;
    bus.resp_rdy = '0;
    reset    = 1'b1;
    m_ptr    = 0;
    m_ops    = 16'd0;
    mx_delay = 1;
    clear_logs();
    op_msg[1] = rand_op();
    op_msg[2] = {32'd1000, 32'd10, 32'd2};
    model_round(4'b0110);
    run_round(4'b0110, 1'b1, to);
    m_ops = m_ops + 16'd2;
    n_chk++;
    if (to || grant_q.size() != 2 || rsp_own_q.size() != 2) begin
      n_fail++; $display("FAIL mid_after_count: got %0d grants %0d resps want 2 2", grant_q.size(), rsp_own_q.size());
    end else begin
      n_chk++; if (grant_q[0] !== exp_q[0] || grant_q[1] !== exp_q[1]) begin
        n_fail++; $display("FAIL mid_after_order: got %0d,%0d want %0d,%0d", grant_q[0], grant_q[1], exp_q[0], exp_q[1]);
      end
      n_chk++; if (rsp_own_q[1] !== 2 || rsp_msg_q[1] !== 32'd24) begin
        n_fail++; $display("FAIL mid_after_result: got owner %0d msg %0d want owner 2 msg 24", rsp_own_q[1], rsp_msg_q[1]);
      end
    end
    n_chk++; if (op_count !== m_ops) begin n_fail++; $display("FAIL mid_op_count: got %0d want %0d", op_count, m_ops); end
  endtask

  task automatic test_wrap();
    bit to;
    @(negedge clk);
    force dut.op_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.op_cnt;
    #1;
    m_ops = 16'hFFFE;
    n_chk++; if (op_count !== m_ops) begin n_fail++; $display("FAIL wrap_preload: got %h want %h", op_count, m_ops); end
    for (int r = 0; r < 2; r++) begin
      clear_logs();
      op_msg[r] = rand_op();
      model_round(4'(1 << r));
      run_round(4'(1 << r), 1'b1, to);
      m_ops = m_ops + 16'd1;
      n_chk++; if (to || op_count !== m_ops) begin n_fail++; $display("FAIL wrap_count: op %0d got %h want %h", r, op_count, m_ops); end
    end
  endtask

  initial begin
    bus.req_val  = '0;
    bus.req_msg  = '0;
    bus.resp_rdy = '0;
    mx_en    = 1'b1;
    mx_delay = 1;
    m_ptr    = 0;
    m_ops    = 16'd0;
    reset    = 1'b1;
    #2 reset = 1'b0;
    test_reset();
    test_single();
    test_round_robin(1'b0);
    test_hold_resp();
    test_istream_stall();
    test_reset_mid();
    test_wrap();
    test_round_robin(1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
